bayer_gray_quad: RTL and testbench

Converts the raw 12-bit Bayer stream from the CCD capture stage into a quarter-resolution grayscale stream, one gray pixel per 2x2 Bayer quad. Sits directly downstream of `CCD_Capture`, in parallel with `RAW2RGB`, and feeds the edge-detection path so that stage receives single-channel 640x480 data with matching coordinates. Uses a one-line buffer to pair each even sensor row with the following odd row.

---
 rtl/bayer_gray_quad_pkg.sv | 30 +++
 rtl/bayer_gray_quad_if.sv | 25 ++
 rtl/bayer_gray_quad_line_ram.sv | 22 ++
 rtl/bayer_gray_quad.sv | 106 ++++++++++
 tb/tb_bayer_gray_quad.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/bayer_gray_quad_pkg.sv
// Shared types and constants for the Bayer-to-gray quad reducer.
// BAYER_GRAY_LUMA_EN selects the weighted luma sum instead of the plain 4-sample mean.
package bayer_gray_pkg;

    localparam int DW_DEFAULT = 12;

    typedef struct packed {
        logic [DW_DEFAULT-1:0] g1;
        logic [DW_DEFAULT-1:0] r;
    } pair_t;

    // Encoding is {row[0], col[0]}, so the position falls straight out of the coordinates
    typedef enum logic [1:0] {
        POS_G1 = 2'b00,
        POS_R  = 2'b01,
        POS_B  = 2'b10,
        POS_G2 = 2'b11
    } bayer_pos_e;

    localparam int LUMA_W_R  = 2;
    localparam int LUMA_W_G1 = 2;
    localparam int LUMA_W_G2 = 3;
    localparam int LUMA_W_B  = 1;
    localparam int LUMA_SH   = 3;

    function automatic bayer_pos_e bayer_pos(input logic y0, input logic x0);
        return bayer_pos_e'({y0, x0});
    endfunction

endpackage

// File: rtl/bayer_gray_quad_if.sv
// Raw Bayer in / gray out stream bundle; master is the stream source, slave is the reducer.
interface bayer_gray_quad_if
    import bayer_gray_pkg::*;
#(
    parameter int DW = DW_DEFAULT
);
    logic [DW-1:0] iDATA;
    logic          iDVAL;
    logic [15:0]   iX_Cont;
    logic [15:0]   iY_Cont;
    logic [DW-1:0] oDATA;
    logic          oDVAL;
    logic [15:0]   oX_Cont;
    logic [15:0]   oY_Cont;

    modport master (
        output iDATA, iDVAL, iX_Cont, iY_Cont,
        input  oDATA, oDVAL, oX_Cont, oY_Cont
    );

    modport slave (
        input  iDATA, iDVAL, iX_Cont, iY_Cont,
        output oDATA, oDVAL, oX_Cont, oY_Cont
    );
endinterface

// File: rtl/bayer_gray_quad_line_ram.sv
// Simple dual-port line RAM with a registered read; no reset so it maps onto block RAM.
module bayer_line_ram #(
    parameter int DEPTH = 640,
    parameter int W     = 24,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];

    // rdata holds between reads so gaps between B and G2 keep the fetched pair
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/bayer_gray_quad.sv
// Reduces each 2x2 Bayer quad to one gray pixel using a one-line {G1,R} buffer.
// Define BAYER_GRAY_LUMA_EN for (2R+2G1+3G2+B)>>3; otherwise the plain mean is used.
module bayer_gray_quad
    import bayer_gray_pkg::*;
#(
    parameter int DW     = DW_DEFAULT,
    parameter int LINE_W = 1280
) (
    input  logic              iCLK,
    input  logic              iRST,
    bayer_gray_quad_if.slave  pix
);
    localparam int DEPTH = LINE_W / 2;
    localparam int AW    = $clog2(DEPTH);

    typedef struct packed {
        logic [DW-1:0] g1;
        logic [DW-1:0] r;
    } pair_w_t;

    bayer_pos_e    pos;
    logic          qual;
    logic          we, re, fire;
    logic [AW-1:0] addr;
    logic [DW-1:0] g1_q, b_q;
    logic [14:0]   tag;
    logic          tag_v, match;
    pair_w_t       rd;
    logic [2*DW-1:0] ram_rdata;
    logic [DW-1:0] gray;

    assign pos  = bayer_pos(pix.iY_Cont[0], pix.iX_Cont[0]);
    assign qual = pix.iDVAL && (int'(pix.iX_Cont) < LINE_W);
    assign addr = AW'(pix.iX_Cont >> 1);
    assign we   = qual && (pos == POS_R);
    assign re   = qual && (pos == POS_B);
    assign fire = qual && (pos == POS_G2) && match;
    assign rd   = ram_rdata;

    bayer_line_ram #(.DEPTH(DEPTH), .W(2*DW), .AW(AW)) u_ram (
        .clk   (iCLK),
        .we    (we),
        .waddr (addr),
        .wdata ({g1_q, pix.iDATA}),
        .re    (re),
        .raddr (addr),
        .rdata (ram_rdata)
    );

`ifdef BAYER_GRAY_LUMA_EN
    logic [DW+2:0] sum;
    always_comb begin
        sum  = (DW+3)'(LUMA_W_R  * rd.r)
             + (DW+3)'(LUMA_W_G1 * rd.g1)
             + (DW+3)'(LUMA_W_G2 * pix.iDATA)
             + (DW+3)'(LUMA_W_B  * b_q);
        gray = DW'(sum >> LUMA_SH);
    end
`else
    logic [DW+1:0] sum;
    always_comb begin
        sum  = (DW+2)'(rd.r) + (DW+2)'(rd.g1) + (DW+2)'(pix.iDATA) + (DW+2)'(b_q);
        gray = DW'(sum >> 2);
    end
`endif

    // tag remembers only the latest even row; an odd row pairs with it only if it is its partner
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            g1_q  <= '0;
            b_q   <= '0;
            tag   <= '0;
            tag_v <= 1'b0;
            match <= 1'b0;
        end else if (qual) begin
            unique case (pos)
                POS_G1: g1_q <= pix.iDATA;
                POS_R: begin
                    tag   <= pix.iY_Cont[15:1];
                    tag_v <= 1'b1;
                end
                POS_B: begin
                    b_q   <= pix.iDATA;
                    match <= tag_v && (tag == pix.iY_Cont[15:1]);
                end
                POS_G2: ;
            endcase
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            pix.oDATA   <= '0;
            pix.oDVAL   <= 1'b0;
            pix.oX_Cont <= '0;
            pix.oY_Cont <= '0;
        end else begin
            pix.oDVAL <= fire;
            if (fire) begin
                pix.oDATA   <= gray;
                pix.oX_Cont <= {1'b0, pix.iX_Cont[15:1]};
                pix.oY_Cont <= {1'b0, pix.iY_Cont[15:1]};
            end
        end
    end
endmodule

// File: tb/tb_bayer_gray_quad.sv
// Scoreboard bench for bayer_gray_quad: expected gray pixels are queued when G2 is driven.
module tb_bayer_gray_quad;
    logic iCLK = 1'b0;
    logic iRST = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    typedef struct {
        logic [11:0] d;
        int x;
        int y;
        int cyc;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    bayer_gray_quad_if #(.DW(12)) pix();

    bayer_gray_quad #(.DW(12), .LINE_W(1280)) dut (
        .iCLK (iCLK),
        .iRST (iRST),
        .pix  (pix)
    );

    always #5 iCLK = ~iCLK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [11:0] gray_f(input int g1, input int r, input int b, input int g2);
`ifdef BAYER_GRAY_LUMA_EN
        return 12'((2*r + 2*g1 + 3*g2 + b) >> 3);
`else
        return 12'((r + g1 + g2 + b) >> 2);
`endif
    endfunction

    task automatic px(input int x, input int y, input int d);
        @(negedge iCLK);
        pix.iDVAL   = 1'b1;
        pix.iX_Cont = 16'(x);
        pix.iY_Cont = 16'(y);
        pix.iDATA   = 12'(d);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge iCLK);
            pix.iDVAL = 1'b0;
        end
    endtask

    // Called right after the G2 sample is driven: output is due on the next rising edge
    task automatic exp_out(input int x, input int y, input logic [11:0] d);
        exp_t t;
        t.d = d; t.x = x >> 1; t.y = y >> 1; t.cyc = cyc + 1;
        sb.push_back(t);
    endtask

    task automatic do_reset();
        @(negedge iCLK);
        pix.iDVAL = 1'b0;
        iRST = 1'b1;
        idle(3);
        iRST = 1'b0;
    endtask

    always @(posedge iCLK) begin
        cyc++;
        #1;
        if (pix.oDVAL) begin
            if (sb.size() == 0) chk("spurious_dval", 32'd1, 32'd0);
            else begin
                e = sb.pop_front();
                chk("odata", 32'(pix.oDATA), 32'(e.d));
                chk("ox", 32'(pix.oX_Cont), 32'(e.x));
                chk("oy", 32'(pix.oY_Cont), 32'(e.y));
                chk("latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        pix.iDVAL = 1'b0; pix.iDATA = '0; pix.iX_Cont = '0; pix.iY_Cont = '0;
        repeat (3) @(negedge iCLK);
        chk("rst_odata", 32'(pix.oDATA), 32'd0);
        chk("rst_odval", 32'(pix.oDVAL), 32'd0);
        chk("rst_ox", 32'(pix.oX_Cont), 32'd0);
        chk("rst_oy", 32'(pix.oY_Cont), 32'd0);
        iRST = 1'b0;
        idle(2);

        // constant 4x4 patch
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 4; x++) begin
                px(x, y, 12'h800);
                if ((y & 1) && (x & 1)) exp_out(x, y, 12'h800);
            end
        end
        idle(2);

        // distinct quad values
        px(0, 4, 12'h100); px(1, 4, 12'h200);
        px(0, 5, 12'h300); px(1, 5, 12'h400);
        exp_out(1, 5, gray_f(12'h100, 12'h200, 12'h300, 12'h400));
        idle(2);

        // 5-cycle valid gap between B and G2, full-scale samples
        px(2, 6, 12'hFFF); px(3, 6, 12'hFFF);
        px(2, 7, 12'hFFF);
        idle(5);
        px(3, 7, 12'hFFF);
        exp_out(3, 7, gray_f(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF));
        idle(2);

        // out-of-line samples must not write, read or emit
        px(0, 8, 12'h123); px(1, 8, 12'h456);
        px(1278, 8, 12'h0AA); px(1279, 8, 12'h0BB);
        px(1280, 8, 12'hEEE); px(1281, 8, 12'hDDD);
        px(0, 9, 12'h789); px(1, 9, 12'hABC);
        exp_out(1, 9, gray_f(12'h123, 12'h456, 12'h789, 12'hABC));
        px(1278, 9, 12'h0CC); px(1279, 9, 12'h0DD);
        exp_out(1279, 9, gray_f(12'h0AA, 12'h0BB, 12'h0CC, 12'h0DD));
        px(1280, 9, 12'hFFF); px(1281, 9, 12'hFFF);
        idle(3);

        // reset asserted in row 1 right after an output, stream resumes at row 1
        do_reset();
        for (int x = 0; x < 4; x++) px(x, 0, 12'h200 + x);
        px(0, 1, 12'h300); px(1, 1, 12'h400);
        exp_out(1, 1, gray_f(12'h200, 12'h201, 12'h300, 12'h400));
        @(negedge iCLK);
        pix.iDVAL = 1'b0;
        chk("pre_rst_dval", 32'(pix.oDVAL), 32'd1);
        iRST = 1'b1;
        #1;
        chk("async_rst_dval", 32'(pix.oDVAL), 32'd0);
        chk("async_rst_odata", 32'(pix.oDATA), 32'd0);
        idle(2);
        iRST = 1'b0;
        for (int x = 0; x < 4; x++) px(x, 1, 12'h500);
        for (int y = 2; y < 4; y++) begin
            for (int x = 0; x < 4; x++) begin
                px(x, y, 12'h040 * (x + 1));
                if ((y & 1) && (x & 1))
                    exp_out(x, y, gray_f(12'h040 * x, 12'h040 * (x + 1), 12'h040 * x, 12'h040 * (x + 1)));
            end
        end
        idle(2);

        // stream starting at odd row 5, then a dropped quad missing its G2
        do_reset();
        for (int x = 0; x < 4; x++) px(x, 5, 12'h300);
        for (int x = 0; x < 6; x++) px(x, 6, 12'h010 * (x + 1));
        px(0, 7, 12'h070); px(1, 7, 12'h080);
        exp_out(1, 7, gray_f(12'h010, 12'h020, 12'h070, 12'h080));
        px(2, 7, 12'hFFF);
        px(4, 7, 12'h0A0); px(5, 7, 12'h0B0);
        exp_out(5, 7, gray_f(12'h050, 12'h060, 12'h0A0, 12'h0B0));
        idle(4);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
